operand_fetch: RTL and testbench



---
 rtl/operand_pkg.sv | 11 +
 rtl/reg_file.sv | 39 +++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/operand_pkg.sv
// Shared widths, register indices and types for the operand-fetch stage.
package operand_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int REG_A0     = 10;

    typedef logic [2:0]            alu_ctrl_t;
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/reg_file.sv
// Register file: x0 hard-wired to zero, two combinational reads, one write, a0 tap.
// Latency: write visible on the cycle after wb_en; no backpressure.
module reg_file
    import operand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] a0
);
    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Reset has priority, so a write-back landing in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    assign a0     = regs_q[REG_A0];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register read, pending-write scoreboard, one-deep output register.
// Latency 1 cycle accept-to-out_valid; stalls on scoreboard hazard or held output.
// Optional OPERAND_BYPASS_EN: forward same-cycle write-back data into captured operands.
module operand_fetch
    import operand_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  ALUsrc,
    input  logic [2:0]            ALUctrl_in,
    input  logic                  reg_write_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [ADDR_WIDTH-1:0] rd_out,
    output logic                  reg_write_out,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] a0
);
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                out_valid_q, out_valid_d;
    data_t               op1_q, op1_d, op2_q, op2_d;
    alu_ctrl_t           ctrl_q, ctrl_d;
    reg_addr_t           rd_q, rd_d;
    logic                rw_q, rw_d;

    data_t rdata1, rdata2, src1, src2;
    logic  byp1, byp2, hazard, accept;

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .raddr1  (rs1),
        .raddr2  (rs2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .a0      (a0)
    );

`ifdef OPERAND_BYPASS_EN
    assign byp1 = wb_en && (wb_addr == rs1) && (rs1 != '0);
    assign byp2 = wb_en && (wb_addr == rs2) && (rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        src1   = byp1 ? wb_data : rdata1;
        src2   = byp2 ? wb_data : rdata2;
        // pend_q[0] is never set, so x0 reads cannot stall.
        hazard = (pend_q[rs1] && !byp1) || (!ALUsrc && pend_q[rs2] && !byp2);
        in_ready = !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        pend_d      = pend_q;
        out_valid_d = out_valid_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        ctrl_d      = ctrl_q;
        rd_d        = rd_q;
        rw_d        = rw_q;

        // Clear first so a same-cycle set of the same register wins.
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (accept && reg_write_in && (rd != '0)) begin
            pend_d[rd] = 1'b1;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            op1_d       = src1;
            op2_d       = ALUsrc ? imm : src2;
            ctrl_d      = ALUctrl_in;
            rd_d        = rd;
            rw_d        = reg_write_in;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign ALUop1        = op1_q;
    assign ALUop2        = op2_q;
    assign ALUctrl       = ctrl_q;
    assign rd_out        = rd_q;
    assign reg_write_out = rw_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with an expected-result queue.
module tb_operand_fetch;
    import operand_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic        ALUsrc = 1'b0;
    logic [2:0]  ALUctrl_in = '0;
    logic        reg_write_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUop1, ALUop2;
    logic [2:0]  ALUctrl;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] a0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .imm           (imm),
        .ALUsrc        (ALUsrc),
        .ALUctrl_in    (ALUctrl_in),
        .reg_write_in  (reg_write_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALUop1        (ALUop1),
        .ALUop2        (ALUop2),
        .ALUctrl       (ALUctrl),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .a0            (a0)
    );

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    exp_t q[$];
    exp_t nxt = '0;
    exp_t last = '0;
    logic ov = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic [31:0] im, input logic src, input logic [2:0] c,
                         input logic w, input logic [31:0] e1, input logic [31:0] e2);
        in_valid     = 1'b1;
        rs1          = r1;
        rs2          = r2;
        rd           = d;
        imm          = im;
        ALUsrc       = src;
        ALUctrl_in   = c;
        reg_write_in = w;
        nxt          = '{op1: e1, op2: e2, ctrl: c, rd: d, rw: w};
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en   = en;
        wb_addr = a;
        wb_data = d;
    endtask

    // One clock: check in_ready, queue the expected capture, then check all outputs.
    task automatic cyc(input logic exp_rdy);
        logic acc, ordy, was_rst;
        #1;
        was_rst = rst;
        ordy    = out_ready;
        if (!rst) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc = !rst && in_valid && exp_rdy;
        if (acc) q.push_back(nxt);
        @(posedge clk);
        #1;
        if (was_rst) begin
            q.delete();
            ov   = 1'b0;
            last = '0;
        end else if (acc) begin
            last = q.pop_front();
            ov   = 1'b1;
        end else if (ordy) begin
            ov = 1'b0;
        end
        chk("out_valid",     {31'b0, out_valid},     {31'b0, ov});
        chk("ALUop1",        ALUop1,                 last.op1);
        chk("ALUop2",        ALUop2,                 last.op2);
        chk("ALUctrl",       {29'b0, ALUctrl},       {29'b0, last.ctrl});
        chk("rd_out",        {27'b0, rd_out},        {27'b0, last.rd});
        chk("reg_write_out", {31'b0, reg_write_out}, {31'b0, last.rw});
    endtask

    initial begin
        // Reset; a write-back during the reset cycle must be dropped.
        cyc(1'b1);
        wb(1'b1, 5'd10, 32'h55);
        cyc(1'b1);
        rst = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        chk("a0_after_rst_wb", a0, 32'h0);
        cyc(1'b1);

        // Populate x5, x0 (ignored) and x10.
        wb(1'b1, 5'd5, 32'd7);
        cyc(1'b1);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        cyc(1'b1);
        wb(1'b1, 5'd10, 32'hA0A0);
        cyc(1'b1);
        wb(1'b0, 5'd0, 32'h0);
        chk("a0_written", a0, 32'hA0A0);

        // addi-style read of x5 with immediate.
        issue(5'd5, 5'd0, 5'd6, 32'd3, 1'b1, 3'd0, 1'b0, 32'd7, 32'd3);
        cyc(1'b1);
        // x0 reads zero after a write attempt, no stall.
        issue(5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd2, 1'b0, 32'd0, 32'd0);
        cyc(1'b1);
        // Register-register read; marks x4 pending.
        issue(5'd5, 5'd5, 5'd4, 32'h0, 1'b0, 3'd1, 1'b1, 32'd7, 32'd7);
        cyc(1'b1);
        // Dependent read of x4 stalls.
        issue(5'd4, 5'd0, 5'd7, 32'd1, 1'b1, 3'd3, 1'b0, 32'h12, 32'd1);
        cyc(1'b0);
        wb(1'b1, 5'd4, 32'h12);
`ifdef OPERAND_BYPASS_EN
        cyc(1'b1);
        wb(1'b0, 5'd0, 32'h0);
`else
        cyc(1'b0);
        wb(1'b0, 5'd0, 32'h0);
        cyc(1'b1);
`endif

        // Output stall: hold out_ready low for three cycles.
        issue(5'd5, 5'd0, 5'd8, 32'd9, 1'b1, 3'd4, 1'b0, 32'd7, 32'd9);
        cyc(1'b1);
        out_ready = 1'b0;
        issue(5'd0, 5'd0, 5'd9, 32'h33, 1'b1, 3'd5, 1'b1, 32'd0, 32'h33);
        for (int i = 0; i < 3; i++) cyc(1'b0);
        out_ready = 1'b1;
        cyc(1'b1);
        in_valid = 1'b0;
        cyc(1'b1);

        // Reset with a held instruction and x4 pending.
        issue(5'd5, 5'd0, 5'd4, 32'h0, 1'b1, 3'd6, 1'b1, 32'd7, 32'd0);
        cyc(1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc(1'b0);
        rst = 1'b1;
        cyc(1'b0);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("a0_after_rst", a0, 32'h0);
        issue(5'd4, 5'd4, 5'd0, 32'h0, 1'b0, 3'd7, 1'b0, 32'd0, 32'd0);
        cyc(1'b1);
        in_valid = 1'b0;
        cyc(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
